fifo_sync_param: RTL and testbench

- Parametrised successor to the team's single-clock FIFO.
- Adds arbitrary (non-power-of-two) depth, programmable almost-full/almost-empty thresholds, an occupancy count output, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer logic in one clock domain and plugs into the existing FIFO verification environment.

---
 rtl/fifo_sync_param.sv | 131 +++++++++++++
 tb/tb_fifo_sync_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Single-clock FIFO with arbitrary depth, programmable almost-full /
//   almost-empty thresholds, an occupancy count and a selectable
//   first-word-fall-through read mode.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous reset, active-high (stored words are discarded)
//   wr_en        write request
//   data_in      write data
//   rd_en        read request (FWFT: pop of the head word)
//   data_out     read data (registered in standard mode, head word in FWFT)
//   full         count == FIFO_DEPTH
//   empty        count == 0
//   almostfull   count >= AF_THR
//   almostempty  count <= AE_THR
//   count        current occupancy
//   wr_ack       one-cycle pulse: previous-cycle write accepted
//   overflow     one-cycle pulse: previous-cycle write rejected
//   underflow    one-cycle pulse: previous-cycle read rejected
module fifo_sync_param #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_THR     = FIFO_DEPTH - 1,
  parameter int unsigned AE_THR     = 1,
  parameter int unsigned FWFT       = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            full,
  output logic                            empty,
  output logic                            almostfull,
  output logic                            almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            wr_ack,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THR);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THR);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Depth need not be a power of two, so wrap by compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Status flags decode from the registered count.
  always_comb begin
    full        = (count == CNT_FULL);
    empty       = (count == '0);
    almostfull  = (count >= AF_LVL);
    almostempty = (count <= AE_LVL);
  end

  // A read never succeeds on an empty FIFO, so a same-cycle write is not
  // bypassed. A full FIFO accepts a write when the read frees a slot.
  always_comb begin
    rd_ok = rd_en && !empty;
    wr_ok = wr_en && (!full || rd_ok);
  end

  // Storage is not reset; reset only blocks the write in that cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_ok;
      overflow  <= wr_en && !wr_ok;
      underflow <= rd_en && !rd_ok;
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out <= '0;
        end else if (rd_ok) begin
          data_out <= mem[rd_ptr];
        end
      end
    end else begin : g_fwft_read
      // Head word is presented directly; forced to zero while empty.
      always_comb begin
        data_out = '0;
        if (!empty) begin
          data_out = mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  typedef struct packed {
    logic        rst;
    logic        wr;
    logic        rd;
    logic [15:0] din;
  } in_t;

  typedef struct packed {
    logic [15:0] dout;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        af;
    logic        ae;
    logic        ack;
    logic        ovf;
    logic        udf;
  } out_t;

  typedef struct {
    in_t  vin;
    out_t vexp;
  } vec_t;

  localparam in_t IDLE = '{rst: 1'b0, wr: 1'b0, rd: 1'b0, din: 16'h0000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t  ia, ib, ic;
  out_t oa, ob, oc;

  int checks   = 0;
  int failures = 0;

  // A: depth 8, standard read
  logic [15:0] dout_a;
  logic [3:0]  cnt_a;
  logic        full_a, empty_a, af_a, ae_a, ack_a, ovf_a, udf_a;
  // B: depth 6, standard read
  logic [15:0] dout_b;
  logic [2:0]  cnt_b;
  logic        full_b, empty_b, af_b, ae_b, ack_b, ovf_b, udf_b;
  // C: depth 8, FWFT
  logic [15:0] dout_c;
  logic [3:0]  cnt_c;
  logic        full_c, empty_c, af_c, ae_c, ack_c, ovf_c, udf_c;

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THR(7), .AE_THR(1), .FWFT(0)) dut_a (
    .clk(clk), .rst(ia.rst), .wr_en(ia.wr), .data_in(ia.din), .rd_en(ia.rd),
    .data_out(dout_a), .full(full_a), .empty(empty_a), .almostfull(af_a),
    .almostempty(ae_a), .count(cnt_a), .wr_ack(ack_a), .overflow(ovf_a),
    .underflow(udf_a)
  );

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_THR(5), .AE_THR(1), .FWFT(0)) dut_b (
    .clk(clk), .rst(ib.rst), .wr_en(ib.wr), .data_in(ib.din), .rd_en(ib.rd),
    .data_out(dout_b), .full(full_b), .empty(empty_b), .almostfull(af_b),
    .almostempty(ae_b), .count(cnt_b), .wr_ack(ack_b), .overflow(ovf_b),
    .underflow(udf_b)
  );

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .AF_THR(7), .AE_THR(1), .FWFT(1)) dut_c (
    .clk(clk), .rst(ic.rst), .wr_en(ic.wr), .data_in(ic.din), .rd_en(ic.rd),
    .data_out(dout_c), .full(full_c), .empty(empty_c), .almostfull(af_c),
    .almostempty(ae_c), .count(cnt_c), .wr_ack(ack_c), .overflow(ovf_c),
    .underflow(udf_c)
  );

  assign oa = {dout_a, cnt_a, full_a, empty_a, af_a, ae_a, ack_a, ovf_a, udf_a};
  assign ob = {dout_b, 1'b0, cnt_b, full_b, empty_b, af_b, ae_b, ack_b, ovf_b, udf_b};
  assign oc = {dout_c, cnt_c, full_c, empty_c, af_c, ae_c, ack_c, ovf_c, udf_c};

  function automatic in_t iv(input logic r, input logic w, input logic rd, input logic [15:0] d);
    in_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.din = d;
    return v;
  endfunction

  // Expected outputs: flags follow from the expected occupancy.
  function automatic out_t mk(input logic [15:0] d, input int c, input logic ack,
                              input logic ovf, input logic udf, input int depth,
                              input int afthr, input int aethr);
    out_t e;
    e.dout  = d;
    e.cnt   = 4'(c);
    e.full  = (c == depth);
    e.empty = (c == 0);
    e.af    = (c >= afthr);
    e.ae    = (c <= aethr);
    e.ack   = ack;
    e.ovf   = ovf;
    e.udf   = udf;
    return e;
  endfunction

  function automatic out_t mk8(input logic [15:0] d, input int c, input logic ack,
                               input logic ovf, input logic udf);
    return mk(d, c, ack, ovf, udf, 8, 7, 1);
  endfunction

  function automatic out_t mk6(input logic [15:0] d, input int c, input logic ack,
                               input logic ovf, input logic udf);
    return mk(d, c, ack, ovf, udf, 6, 5, 1);
  endfunction

  task automatic step(input int unsigned sel, input in_t v, input out_t e, input string nm);
    out_t o;
    @(negedge clk);
    ia = IDLE; ib = IDLE; ic = IDLE;
    case (sel)
      0:       ia = v;
      1:       ib = v;
      default: ic = v;
    endcase
    @(posedge clk);
    #1;
    case (sel)
      0:       o = oa;
      1:       o = ob;
      default: o = oc;
    endcase
    checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL %s: got dout=%h cnt=%0d f/e/af/ae=%b%b%b%b ack/ovf/udf=%b%b%b, want dout=%h cnt=%0d f/e/af/ae=%b%b%b%b ack/ovf/udf=%b%b%b",
               nm, o.dout, o.cnt, o.full, o.empty, o.af, o.ae, o.ack, o.ovf, o.udf,
               e.dout, e.cnt, e.full, e.empty, e.af, e.ae, e.ack, e.ovf, e.udf);
    end
  endtask

  vec_t tab[$];

  task automatic add(input in_t v, input out_t e);
    vec_t t;
    t.vin  = v;
    t.vexp = e;
    tab.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    ia = IDLE; ib = IDLE; ic = IDLE;
    ia.rst = 1'b1; ib.rst = 1'b1; ic.rst = 1'b1;
    repeat (2) @(posedge clk);

    // ---- table for DUT A (depth 8, standard read) ----
    // reset dominates simultaneous requests
    add(iv(1, 1, 1, 16'h1234), mk8(16'h0000, 0, 0, 0, 0));
    add(iv(1, 1, 1, 16'h1234), mk8(16'h0000, 0, 0, 0, 0));
    // fill, then overflow
    for (int i = 0; i < 8; i++)
      add(iv(0, 1, 0, 16'h1000 + 16'(i)), mk8(16'h0000, i + 1, 1, 0, 0));
    add(iv(0, 1, 0, 16'hDEAD), mk8(16'h0000, 8, 0, 1, 0));
    // drain, then underflow with data_out holding
    for (int i = 0; i < 8; i++)
      add(iv(0, 0, 1, 16'h0000), mk8(16'h1000 + 16'(i), 7 - i, 0, 0, 0));
    add(iv(0, 0, 1, 16'h0000), mk8(16'h1007, 0, 0, 0, 1));
    add(iv(0, 0, 0, 16'h0000), mk8(16'h1007, 0, 0, 0, 0));
    // full + simultaneous write/read
    for (int i = 0; i < 8; i++)
      add(iv(0, 1, 0, 16'h2000 + 16'(i)), mk8(16'h1007, i + 1, 1, 0, 0));
    add(iv(0, 1, 1, 16'hBEEF), mk8(16'h2000, 8, 1, 0, 0));
    for (int i = 1; i < 8; i++)
      add(iv(0, 0, 1, 16'h0000), mk8(16'h2000 + 16'(i), 8 - i, 0, 0, 0));
    add(iv(0, 0, 1, 16'h0000), mk8(16'hBEEF, 0, 0, 0, 0));
    // empty + simultaneous: write lands, read rejected
    add(iv(0, 1, 1, 16'h3333), mk8(16'hBEEF, 1, 1, 0, 1));
    // non-empty, non-full simultaneous: count unchanged
    add(iv(0, 1, 1, 16'h4444), mk8(16'h3333, 1, 1, 0, 0));
    add(iv(0, 0, 1, 16'h0000), mk8(16'h4444, 0, 0, 0, 0));
    // reset mid-stream discards stored words
    add(iv(0, 1, 0, 16'h5555), mk8(16'h4444, 1, 1, 0, 0));
    add(iv(0, 1, 0, 16'h6666), mk8(16'h4444, 2, 1, 0, 0));
    add(iv(1, 1, 1, 16'h7777), mk8(16'h0000, 0, 0, 0, 0));
    add(iv(0, 0, 1, 16'h0000), mk8(16'h0000, 0, 0, 0, 1));

    foreach (tab[k])
      step(0, tab[k].vin, tab[k].vexp, $sformatf("a_vec%0d", k));

    // ---- DUT B: depth 6 wrap ----
    step(1, iv(1, 0, 0, 16'h0000), mk6(16'h0000, 0, 0, 0, 0), "b_reset");
    for (int i = 0; i < 4; i++)
      step(1, iv(0, 1, 0, 16'h0050 + 16'(i)), mk6(16'h0000, i + 1, 1, 0, 0), $sformatf("b_wr4_%0d", i));
    for (int i = 0; i < 4; i++)
      step(1, iv(0, 0, 1, 16'h0000), mk6(16'h0050 + 16'(i), 3 - i, 0, 0, 0), $sformatf("b_rd4_%0d", i));
    for (int i = 0; i < 6; i++)
      step(1, iv(0, 1, 0, 16'h0060 + 16'(i)), mk6(16'h0053, i + 1, 1, 0, 0), $sformatf("b_wr6_%0d", i));
    step(1, iv(0, 1, 0, 16'h0077), mk6(16'h0053, 6, 0, 1, 0), "b_ovf");
    for (int i = 0; i < 6; i++)
      step(1, iv(0, 0, 1, 16'h0000), mk6(16'h0060 + 16'(i), 5 - i, 0, 0, 0), $sformatf("b_rd6_%0d", i));

    // ---- DUT C: first-word-fall-through ----
    step(2, iv(1, 1, 1, 16'hFFFF), mk8(16'h0000, 0, 0, 0, 0), "c_reset");
    step(2, iv(0, 1, 0, 16'hA5A5), mk8(16'hA5A5, 1, 1, 0, 0), "c_wr_visible");
    step(2, iv(0, 0, 0, 16'h0000), mk8(16'hA5A5, 1, 0, 0, 0), "c_hold");
    step(2, iv(0, 0, 1, 16'h0000), mk8(16'h0000, 0, 0, 0, 0), "c_pop");
    step(2, iv(0, 0, 1, 16'h0000), mk8(16'h0000, 0, 0, 0, 1), "c_udf");
    step(2, iv(0, 1, 1, 16'h1111), mk8(16'h1111, 1, 1, 0, 1), "c_empty_wr_rd");
    step(2, iv(0, 1, 0, 16'h0022), mk8(16'h1111, 2, 1, 0, 0), "c_wr2");
    step(2, iv(0, 1, 0, 16'h0033), mk8(16'h1111, 3, 1, 0, 0), "c_wr3");
    step(2, iv(0, 0, 1, 16'h0000), mk8(16'h0022, 2, 0, 0, 0), "c_pop_head");
    step(2, iv(0, 1, 0, 16'h0044), mk8(16'h0022, 3, 1, 0, 0), "c_wr_cnt3");
    step(2, iv(1, 1, 0, 16'h0055), mk8(16'h0000, 0, 0, 0, 0), "c_mid_reset");
    step(2, iv(0, 0, 0, 16'h0000), mk8(16'h0000, 0, 0, 0, 0), "c_after_reset");
    step(2, iv(0, 1, 0, 16'h0099), mk8(16'h0099, 1, 1, 0, 0), "c_fresh_head");

    @(negedge clk);
    ia = IDLE; ib = IDLE; ic = IDLE;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
